// File: rtl/alu_mdu_seq.sv
// Registered, handshaked execute-stage ALU with an iterative radix-2 multiply/divide engine.
// Base ALU ops and illegal opcodes retire after one cycle; RV32M-style ops take XLEN+2 cycles.
module alu_mdu_seq #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   operand1,
   input  logic [XLEN-1:0]   operand2,
   input  logic [CTRL_W-1:0] alu_control,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              zero,
   output logic              illegal
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_FIX,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      MD_MUL,
      MD_MULH,
      MD_MULHSU,
      MD_MULHU,
      MD_DIV,
      MD_DIVU,
      MD_REM,
      MD_REMU
   } md_op_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   res_q;
   logic              ill_q;
   logic [XLEN-1:0]   accHi_q, accLo_q, opB_q;
   md_op_e            mdOp_q;
   logic              negQ_q, negR_q;

   logic              accept;
   logic              isMd;
   md_op_e            mdOp;
   logic [XLEN-1:0]   aluRes;
   logic              aluIllegal;
   logic [SH_W-1:0]   shamt;
   logic              sign1, sign2, op1Neg, op2Neg, divZero;
   logic [XLEN-1:0]   mag1, mag2;
   logic              negQ, negR;
   logic [XLEN:0]     mulSum, remShift, remDiff;
   logic [XLEN-1:0]   stepHi, stepLo;
   logic [2*XLEN-1:0] prod, prodAdj;
   logic [XLEN-1:0]   quot, remv, fixRes;

   assign accept = in_valid && (state_q == S_IDLE) && !flush;
   assign shamt  = operand2[SH_W-1:0];

   always_comb begin
      isMd = 1'b1;
      mdOp = MD_MUL;
      case (alu_control)
         CTRL_W'(10): mdOp = MD_MUL;
         CTRL_W'(11): mdOp = MD_MULH;
         CTRL_W'(12): mdOp = MD_MULHSU;
         CTRL_W'(13): mdOp = MD_MULHU;
         CTRL_W'(14): mdOp = MD_DIV;
         CTRL_W'(15): mdOp = MD_DIVU;
         CTRL_W'(16): mdOp = MD_REM;
         CTRL_W'(17): mdOp = MD_REMU;
         default:     isMd = 1'b0;
      endcase
   end

   // Single-cycle datapath; anything that is neither a base ALU op nor a mul/div op is illegal.
   always_comb begin
      aluRes     = '0;
      aluIllegal = 1'b0;
      case (alu_control)
         CTRL_W'(0): aluRes = operand1 & operand2;
         CTRL_W'(1): aluRes = operand1 | operand2;
         CTRL_W'(2): aluRes = operand1 + operand2;
         CTRL_W'(3): aluRes = operand1 << shamt;
         CTRL_W'(4): aluRes = operand1 >> shamt;
         CTRL_W'(5): aluRes = $signed(operand1) >>> shamt;
         CTRL_W'(6): aluRes = operand1 - operand2;
         CTRL_W'(7): aluRes = {{(XLEN-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
         CTRL_W'(8): aluRes = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
         CTRL_W'(9): aluRes = operand1 ^ operand2;
         default:    aluIllegal = !isMd;
      endcase
   end

   // The engine works on magnitudes; the result signs are remembered and applied in FIX.
   // A zero divisor must leave the all-ones quotient un-negated.
   always_comb begin
      sign1 = 1'b0;
      sign2 = 1'b0;
      case (mdOp)
         MD_MULH:        begin sign1 = 1'b1; sign2 = 1'b1; end
         MD_MULHSU:      sign1 = 1'b1;
         MD_DIV, MD_REM: begin sign1 = 1'b1; sign2 = 1'b1; end
         default:        ;
      endcase
      op1Neg  = sign1 && operand1[XLEN-1];
      op2Neg  = sign2 && operand2[XLEN-1];
      mag1    = op1Neg ? -operand1 : operand1;
      mag2    = op2Neg ? -operand2 : operand2;
      divZero = (operand2 == '0);
      negQ    = mdOp[2] ? ((op1Neg ^ op2Neg) && !divZero) : (op1Neg ^ op2Neg);
      negR    = op1Neg;
   end

   // One iteration: shift-add multiply on {accHi,accLo} with the multiplier in accLo,
   // or restoring divide with the partial remainder in accHi and the quotient shifting into accLo.
   always_comb begin
      mulSum   = {1'b0, accHi_q} + {1'b0, (accLo_q[0] ? opB_q : '0)};
      remShift = {accHi_q, accLo_q[XLEN-1]};
      remDiff  = remShift - {1'b0, opB_q};
      if (mdOp_q[2]) begin
         stepHi = remDiff[XLEN] ? remShift[XLEN-1:0] : remDiff[XLEN-1:0];
         stepLo = {accLo_q[XLEN-2:0], ~remDiff[XLEN]};
      end else begin
         stepHi = mulSum[XLEN:1];
         stepLo = {mulSum[0], accLo_q[XLEN-1:1]};
      end
   end

   always_comb begin
      prod    = {accHi_q, accLo_q};
      prodAdj = negQ_q ? -prod : prod;
      quot    = negQ_q ? -accLo_q : accLo_q;
      remv    = negR_q ? -accHi_q : accHi_q;
      case (mdOp_q)
         MD_MUL:                        fixRes = prodAdj[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  fixRes = prodAdj[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               fixRes = quot;
         default:                       fixRes = remv;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid) state_d = isMd ? S_BUSY : S_DONE;
         S_BUSY: if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      result    = res_q;
      zero      = (res_q == '0);
      illegal   = ill_q;
   end

   // Result registers only change on a real accept or at the end of FIX, so a flush leaves them as they were.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         res_q   <= '0;
         ill_q   <= 1'b0;
         accHi_q <= '0;
         accLo_q <= '0;
         opB_q   <= '0;
         mdOp_q  <= MD_MUL;
         negQ_q  <= 1'b0;
         negR_q  <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
         if (isMd) begin
            accHi_q <= '0;
            accLo_q <= mag1;
            opB_q   <= mag2;
            mdOp_q  <= mdOp;
            negQ_q  <= negQ;
            negR_q  <= negR;
         end else begin
            res_q <= aluRes;
            ill_q <= aluIllegal;
         end
      end else if (state_q == S_BUSY && !flush) begin
         accHi_q <= stepHi;
         accLo_q <= stepLo;
         cnt_q   <= cnt_q + CNT_W'(1);
      end else if (state_q == S_FIX && !flush) begin
         res_q <= fixRes;
         ill_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq: directed vector table, handshake/flush/reset sequences,
// and randomized ops compared against an arithmetic reference model.
module tb_alu_mdu_seq;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 5;
   localparam int MD_LAT = XLEN + 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [XLEN-1:0]   operand1 = '0;
   logic [XLEN-1:0]   operand2 = '0;
   logic [CTRL_W-1:0] alu_control = '0;
   logic              in_ready, out_valid, zero, illegal;
   logic [XLEN-1:0]   result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expRes;
      logic        expIll;
      int          expLat;
   } vec_t;

   vec_t vecs[$];

   alu_mdu_seq #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .operand1(operand1),
      .operand2(operand2),
      .alu_control(alu_control),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .zero(zero),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: plain integer arithmetic on 64-bit values; returns {illegal, result}.
   function automatic logic [32:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic [31:0]     r;
      logic            ill;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      r   = '0;
      p   = '0;
      ill = 1'b0;
      case (op)
         5'd0:  r = a & b;
         5'd1:  r = a | b;
         5'd2:  r = a + b;
         5'd3:  r = a << b[4:0];
         5'd4:  r = a >> b[4:0];
         5'd5:  r = $signed(a) >>> b[4:0];
         5'd6:  r = a - b;
         5'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
         5'd8:  r = (ua < ub) ? 32'd1 : 32'd0;
         5'd9:  r = a ^ b;
         5'd10: begin p = ua * ub; r = p[31:0]; end
         5'd11: begin p = sa * sb; r = p[63:32]; end
         5'd12: begin p = sa * longint'(ub); r = p[63:32]; end
         5'd13: begin p = ua * ub; r = p[63:32]; end
         5'd14: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         5'd15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd16: r = (b == 0) ? a : 32'(sa % sb);
         5'd17: r = (b == 0) ? a : a % b;
         default: ill = 1'b1;
      endcase
      return {ill, r};
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic addVec(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expIll, input int expLat);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b;
      v.expRes = expRes; v.expIll = expIll; v.expLat = expLat;
      vecs.push_back(v);
   endtask

   // Offer one op, wait for the accept edge, then count edges until out_valid is seen.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
      int budget;
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) checkOutput("issue_in_ready", in_ready, 1);
      in_valid    = 1'b1;
      alu_control = op;
      operand1    = a;
      operand2    = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [32:0] expv;
      logic [4:0]  op;
      logic [31:0] a, b;
      logic        seen;

      addVec("add_ovf",      5'd2,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1);
      addVec("sub_zero",     5'd6,  32'd5,         32'd5,         32'h0,         1'b0, 1);
      addVec("sra_shamt",    5'd5,  32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1);
      addVec("sltu",         5'd8,  32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1);
      addVec("slt_neg",      5'd7,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1);
      addVec("and",          5'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
      addVec("or",           5'd1,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
      addVec("xor",          5'd9,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1);
      addVec("sll",          5'd3,  32'd1,         32'h1F,        32'h8000_0000, 1'b0, 1);
      addVec("srl",          5'd4,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1);
      addVec("mulh_min",     5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, MD_LAT);
      addVec("mulhsu_ones",  5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MD_LAT);
      addVec("mulhu_ones",   5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MD_LAT);
      addVec("mul_low",      5'd10, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 1'b0, MD_LAT);
      addVec("div_by_zero",  5'd14, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, MD_LAT);
      addVec("divn_by_zero", 5'd14, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, MD_LAT);
      addVec("remu_by_zero", 5'd17, 32'd7,         32'd0,         32'd7,         1'b0, MD_LAT);
      addVec("remn_by_zero", 5'd16, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, MD_LAT);
      addVec("div_ovf",      5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, MD_LAT);
      addVec("rem_ovf",      5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, MD_LAT);
      addVec("div_neg",      5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, MD_LAT);
      addVec("rem_neg",      5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, MD_LAT);
      addVec("divu",         5'd15, 32'd100,       32'd7,         32'd14,        1'b0, MD_LAT);
      addVec("illegal_31",   5'd31, 32'd9,         32'd9,         32'h0,         1'b1, 1);
      addVec("illegal_18",   5'd18, 32'd9,         32'd9,         32'h0,         1'b1, 1);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_zero", zero, 1);
      checkOutput("reset_illegal", illegal, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         checkOutput({vecs[i].name, "_result"}, result, vecs[i].expRes);
         checkOutput({vecs[i].name, "_illegal"}, illegal, vecs[i].expIll);
         checkOutput({vecs[i].name, "_zero"}, zero, (vecs[i].expRes == 0));
         checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].expLat);
         retire();
      end

      // Hold the result under back-pressure, then retire while offering the next op
      applyStimulus(5'd15, 32'd100, 32'd7, lat);
      checkOutput("hold_latency", lat, MD_LAT);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_result", result, 14);
         checkOutput("hold_in_ready", in_ready, 0);
         checkOutput("hold_out_valid", out_valid, 1);
      end
      @(negedge clk);
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      alu_control = 5'd2;
      operand1    = 32'd3;
      operand2    = 32'd4;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("retire_no_accept_valid", out_valid, 0);
      checkOutput("retire_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("next_accept_valid", out_valid, 1);
      checkOutput("next_accept_result", result, 7);
      retire();

      // Flush a divide in flight
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = 5'd14;
      operand1    = 32'd100;
      operand2    = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_in_ready", in_ready, 1);
      checkOutput("flush_out_valid", out_valid, 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checkOutput("flush_never_valid", seen, 0);

      // An op offered together with flush is dropped
      @(negedge clk);
      flush       = 1'b1;
      in_valid    = 1'b1;
      alu_control = 5'd2;
      operand1    = 32'd1;
      operand2    = 32'd1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_blocks_accept_valid", out_valid, 0);
      checkOutput("flush_blocks_accept_ready", in_ready, 1);

      // Asynchronous reset in the middle of a multiply
      applyStimulus(5'd2, 32'd5, 32'd6, lat);
      checkOutput("pre_reset_result", result, 11);
      retire();
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = 5'd10;
      operand1    = 32'd3;
      operand2    = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midmul_reset_out_valid", out_valid, 0);
      checkOutput("midmul_reset_result", result, 0);
      checkOutput("midmul_reset_zero", zero, 1);
      checkOutput("midmul_reset_illegal", illegal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midmul_reset_in_ready", in_ready, 1);
      applyStimulus(5'd10, 32'd3, 32'd5, lat);
      checkOutput("post_reset_mul_result", result, 15);
      checkOutput("post_reset_mul_latency", lat, MD_LAT);
      retire();

      // Randomized ops against the reference model
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(18, 31));
         else                           op = 5'($urandom_range(0, 17));
         a = pickOperand();
         b = pickOperand();
         expv = refModel(op, a, b);
         applyStimulus(op, a, b, lat);
         checkOutput($sformatf("rand%0d_op%0d_result", n, op), result, expv[31:0]);
         checkOutput($sformatf("rand%0d_op%0d_illegal", n, op), illegal, expv[32]);
         checkOutput($sformatf("rand%0d_op%0d_zero", n, op), zero, (expv[31:0] == 0));
         checkOutput($sformatf("rand%0d_op%0d_latency", n, op), lat, (op >= 5'd10 && op <= 5'd17) ? MD_LAT : 1);
         retire();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Registered, handshaked successor to the single-cycle integer ALU.
- Supports all RV32I ALU ops, generalised to XLEN, plus the RV32M multiply/divide ops.
- Multiply/divide run on an iterative radix-2 engine.
- Sits in the execute stage. The pipeline issues through in_valid/in_ready and retires through out_valid/out_ready; flush aborts an in-flight op on branch redirect or trap.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CTRL_W, 5, width of alu_control.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; drops any op in flight or held
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept an operation
- operand1  input  XLEN  rs1 value
- operand2  input  XLEN  rs2/immediate value
- alu_control  input  CTRL_W  opcode
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- zero  output  1  result == 0
- illegal  output  1  opcode was not defined; valid with out_valid

Behaviour:
- Opcodes 0-9 keep the base encoding: AND, OR, ADD, SLL, SRL, SRA, SUB, SLT, SLTU, XOR.
- Opcodes 10-17 are MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- All other opcodes give result 0, illegal=1, single-op latency.
- Shift amount is operand2[log2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN.
- State machine: IDLE, BUSY, FIX, DONE.
- in_ready = (state==IDLE). An op is accepted when in_valid && in_ready.
- Single-cycle ops and illegal ops: IDLE -> DONE. out_valid rises the cycle after acceptance (latency 1).
- MUL/DIV ops: IDLE -> BUSY, latching operand magnitudes and result-sign flags.
  - BUSY performs one shift-add (mul) or restoring-subtract (div) step per cycle for exactly XLEN cycles, counted by a log2(XLEN)+1-bit counter.
  - FIX applies sign correction and selects the high/low half, quotient or remainder.
  - FIX -> DONE. out_valid rises exactly XLEN+2 cycles after acceptance (34 for XLEN=32).
- Division corner cases:
  - Divide-by-zero: DIV/DIVU quotient = all ones; REM/REMU = operand1. No trap.
  - Signed overflow (most-negative / -1): DIV = operand1, REM = 0.
  - Both cases still take the full XLEN+2 latency (constant-time).
- DONE holds result, zero and illegal stable while out_valid=1 && out_ready=0.
- DONE -> IDLE on out_ready. in_ready is therefore 0 during the handoff cycle, so there is no back-to-back accept in the retire cycle.
- flush has priority over everything:
  - Next state is IDLE and out_valid deasserts the next cycle.
  - An op offered in the same cycle as flush is not accepted.
  - result/zero/illegal keep their last values; they are don't-care when out_valid=0.
- Reset (asynchronous, any state including mid-BUSY): state=IDLE, out_valid=0, result=0, zero=1, illegal=0, counter=0. in_ready=1 after reset deasserts.
- zero is derived from the registered result, never from inputs.

Test Plan:
- ADD 0x7FFFFFFF+1 -> after 1 cycle: result=0x80000000, zero=0. SUB 5-5 -> result=0, zero=1.
- SRA 0x80000000 by operand2=0x21 (shamt=1) -> result=0xC0000000. SLTU 1 vs 0xFFFFFFFF -> result=1.
- MULH 0x80000000*0x80000000 -> out_valid exactly 34 cycles after accept, result=0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 7/0 -> result=0xFFFFFFFF. REMU 7/0 -> result=7. DIV 0x80000000/0xFFFFFFFF -> result=0x80000000. REM same operands -> result=0, zero=1.
- Hold out_ready=0 for 5 cycles after DIVU 100/7 -> result=14 held stable, in_ready=0 throughout. Assert out_ready -> accept next op two cycles later.
- Issue DIV, then assert flush at cycle 10 -> out_valid never rises, in_ready=1 next cycle. Also assert rst_n low mid-MUL -> immediate IDLE, result=0, zero=1; opcode 31 -> illegal=1, result=0.
